// File: rtl/idct_pkg.sv
// Shared types and defaults for the IDCT block arbiter.
//   - idct_arb_state_e : sequencer states (IDLE, START, BUSY, OUT)
//   - coeff_t / block_t : dequantized coefficient and 8x8 block at default widths
//   - ST_* constants    : 2-bit state codes used by the sequencer state register
package idct_pkg;

    localparam int unsigned DEF_BLOCK_SIZE  = 8;
    localparam int unsigned DEF_COEFF_WIDTH = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        OUT   = 2'd3
    } idct_arb_state_e;

    // Dequantized coefficients carry 7 extra bits of headroom.
    typedef logic signed [DEF_COEFF_WIDTH+6:0] coeff_t;
    typedef coeff_t block_t [DEF_BLOCK_SIZE][DEF_BLOCK_SIZE];

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_START = START;
    localparam logic [1:0] ST_BUSY  = BUSY;
    localparam logic [1:0] ST_OUT   = OUT;

endpackage

// File: rtl/idct_block_arbiter_if.sv
// Handshake bundle between block producers, the IDCT datapath, the pixel writer
// and the arbiter.
//   slave  : arbiter view (takes requests / done / result_ready, drives the rest)
//   master : environment view (producers, IDCT, writer)
interface idct_block_arbiter_if
    import idct_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 3,
    parameter int unsigned BLOCK_SIZE  = DEF_BLOCK_SIZE,
    parameter int unsigned COEFF_WIDTH = DEF_COEFF_WIDTH
);
    localparam int unsigned CW     = COEFF_WIDTH + 7;
    localparam int unsigned CHAN_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   req_valid;
    logic signed [CW-1:0] req_coeffs [NUM_REQ][BLOCK_SIZE][BLOCK_SIZE];
    logic [NUM_REQ-1:0]   req_ready;
    logic signed [CW-1:0] idct_coeffs [BLOCK_SIZE][BLOCK_SIZE];
    logic                 idct_start;
    logic                 idct_done;
    logic                 result_valid;
    logic                 result_ready;
    logic [CHAN_W-1:0]    result_chan;
    logic                 busy;
    logic                 err_timeout;

    modport slave (
        input  req_valid, req_coeffs, idct_done, result_ready,
        output req_ready, idct_coeffs, idct_start, result_valid, result_chan, busy,
               err_timeout
    );

    modport master (
        output req_valid, req_coeffs, idct_done, result_ready,
        input  req_ready, idct_coeffs, idct_start, result_valid, result_chan, busy,
               err_timeout
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   req  : request vector
//   last : index of the previous winner; search starts at last+1 and wraps
//   gnt  : one-hot grant (zero when no request)
//   idx  : encoded winner index (zero when no request)
module rr_arbiter #(
    parameter int unsigned N = 3
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] idx
);
    localparam int unsigned IW = $clog2(N);

    logic [IW-1:0] cand;
    logic          found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        cand  = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = IW'((32'(last) + k) % N);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/idct_block_arbiter.sv
// Shares one 8x8 IDCT between NUM_REQ block producers. Grants one requester at a
// time (round robin), holds its block stable for the IDCT, pulses idct_start,
// waits for idct_done and then presents a channel-tagged result to the writer.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : idct_block_arbiter_if.slave (requests, IDCT control, result handshake)
// Optional: define IDCT_ARB_WATCHDOG_EN to abort a BUSY phase after TIMEOUT_CYCLES
// without idct_done and raise a sticky err_timeout.
module idct_block_arbiter
    import idct_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 3,
    parameter int unsigned BLOCK_SIZE     = DEF_BLOCK_SIZE,
    parameter int unsigned COEFF_WIDTH    = DEF_COEFF_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic                 clk,
    input logic                 rst,
    idct_block_arbiter_if.slave bus
);
    localparam int unsigned CW     = COEFF_WIDTH + 7;
    localparam int unsigned CHAN_W = $clog2(NUM_REQ);

    logic [1:0]           state_q, state_d;
    logic signed [CW-1:0] hold_q [BLOCK_SIZE][BLOCK_SIZE];
    logic [CHAN_W-1:0]    chan_q;
    logic [CHAN_W-1:0]    last_q;
    logic [CHAN_W-1:0]    win_idx;
    logic [NUM_REQ-1:0]   win_gnt;
    logic                 grant;
    logic                 timeout;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr (
        .req  (bus.req_valid),
        .last (last_q),
        .gnt  (win_gnt),
        .idx  (win_idx)
    );

    assign grant = (state_q == ST_IDLE) && (|bus.req_valid);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (|bus.req_valid) state_d = ST_START;
            ST_START: state_d = ST_BUSY;
            ST_BUSY: begin
                if (bus.idct_done)  state_d = ST_OUT;
                else if (timeout)   state_d = ST_IDLE;
            end
            ST_OUT:   if (bus.result_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // The hold register only moves on a grant, so the IDCT sees a stable block
    // from START until the writer has accepted the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned r = 0; r < BLOCK_SIZE; r++) begin
                for (int unsigned c = 0; c < BLOCK_SIZE; c++) begin
                    hold_q[r][c] <= '0;
                end
            end
            chan_q <= '0;
            last_q <= CHAN_W'(NUM_REQ - 1);
        end else if (grant) begin
            for (int unsigned r = 0; r < BLOCK_SIZE; r++) begin
                for (int unsigned c = 0; c < BLOCK_SIZE; c++) begin
                    hold_q[r][c] <= bus.req_coeffs[win_idx][r][c];
                end
            end
            chan_q <= win_idx;
            last_q <= win_idx;
        end
    end

`ifdef IDCT_ARB_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_q;
    logic            err_q;

    // wd_q counts completed BUSY cycles; the last allowed cycle is TIMEOUT_CYCLES-1.
    assign timeout = (state_q == ST_BUSY) && !bus.idct_done &&
                     (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_q == ST_START)                   wd_q <= '0;
            else if (state_q == ST_BUSY && !timeout)   wd_q <= wd_q + 1'b1;
            if (timeout) err_q <= 1'b1;
        end
    end

    assign bus.err_timeout = err_q;
`else
    assign timeout         = 1'b0;
    assign bus.err_timeout = 1'b0;
`endif

    // State is already IDLE while rst is held; gate so acceptance is never
    // signalled during reset.
    assign bus.req_ready    = (state_q == ST_IDLE && !rst) ? win_gnt : '0;
    assign bus.idct_start   = (state_q == ST_START);
    assign bus.result_valid = (state_q == ST_OUT);
    assign bus.busy         = (state_q != ST_IDLE);
    assign bus.result_chan  = chan_q;
    assign bus.idct_coeffs  = hold_q;

endmodule

// File: tb/tb_idct_block_arbiter.sv
module tb_idct_block_arbiter;
    import idct_pkg::*;

    localparam int unsigned NR = 3;
    localparam int unsigned BS = 8;
    localparam int unsigned CWID = 9;
    localparam int unsigned W = CWID + 7;
    localparam int unsigned TO = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    idct_block_arbiter_if #(.NUM_REQ(NR), .BLOCK_SIZE(BS), .COEFF_WIDTH(CWID)) bus ();

    idct_block_arbiter #(
        .NUM_REQ        (NR),
        .BLOCK_SIZE     (BS),
        .COEFF_WIDTH    (CWID),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    bit [NR-1:0]       pend;
    int                last_g;
    logic signed [W-1:0] exp_blk [BS][BS];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Round robin reference: first pending index after the previous winner.
    function automatic int pick(input bit [NR-1:0] p, input int last);
        for (int k = 1; k <= int'(NR); k++) begin
            if (p[(last + k) % NR]) return (last + k) % NR;
        end
        return -1;
    endfunction

    task automatic rand_block(input int i);
        for (int r = 0; r < int'(BS); r++)
            for (int c = 0; c < int'(BS); c++)
                bus.req_coeffs[i][r][c] = W'($urandom);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_block(input string tag);
        for (int r = 0; r < int'(BS); r++)
            for (int c = 0; c < int'(BS); c++)
                check(tag, 32'(bus.idct_coeffs[r][c]), 32'(exp_blk[r][c]));
    endtask

    task automatic refill();
        for (int i = 0; i < int'(NR); i++) begin
            if (!pend[i] && $urandom_range(0, 1) == 1) begin
                pend[i] = 1'b1;
                rand_block(i);
            end
        end
        if (pend == '0) begin
            int i = $urandom_range(0, NR - 1);
            pend[i] = 1'b1;
            rand_block(i);
        end
    endtask

    // One idle cycle with no requests and a stray idct_done.
    task automatic idle_cycle();
        bus.req_valid = '0;
        bus.idct_done = 1'b1;
        @(negedge clk);
        check("idle_busy", 32'(bus.busy), 0);
        check("idle_ready", 32'(bus.req_ready), 0);
        check("idle_valid", 32'(bus.result_valid), 0);
        step();
        bus.idct_done = 1'b0;
    endtask

    // Grant whatever is pending; returns after START has been observed.
    task automatic grant_and_start(output int w);
        bus.req_valid = pend;
        w = pick(pend, last_g);
        @(negedge clk);
        check("grant", 32'(bus.req_ready), 32'(1) << w);
        check("grant_busy", 32'(bus.busy), 0);
        check("grant_start", 32'(bus.idct_start), 0);
        check("grant_valid", 32'(bus.result_valid), 0);
        for (int r = 0; r < int'(BS); r++)
            for (int c = 0; c < int'(BS); c++)
                exp_blk[r][c] = bus.req_coeffs[w][r][c];
        step();
        last_g = w;
        pend[w] = 1'b0;
        bus.req_valid = pend;
        rand_block(w);  // producer moves on; held copy must not follow
        @(negedge clk);
        check("start", 32'(bus.idct_start), 1);
        check("start_busy", 32'(bus.busy), 1);
        check("start_chan", 32'(bus.result_chan), 32'(w));
        check("start_ready", 32'(bus.req_ready), 0);
        check("start_valid", 32'(bus.result_valid), 0);
        check_block("hold_start");
        step();
    endtask

    task automatic run_block(input int lat, input int stall, input bit spurious);
        int w;
        grant_and_start(w);
        for (int i = 1; i <= lat; i++) begin
            bus.idct_done = (i == lat);
            @(negedge clk);
            check("busy_start", 32'(bus.idct_start), 0);
            check("busy_valid", 32'(bus.result_valid), 0);
            check("busy_ready", 32'(bus.req_ready), 0);
            check("busy_busy", 32'(bus.busy), 1);
            step();
        end
        bus.idct_done = 1'b0;
        refill();
        bus.req_valid = pend;
        bus.result_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
            bus.idct_done = spurious && (s == 0);
            @(negedge clk);
            check("stall_valid", 32'(bus.result_valid), 1);
            check("stall_chan", 32'(bus.result_chan), 32'(w));
            check("stall_ready", 32'(bus.req_ready), 0);
            check("stall_start", 32'(bus.idct_start), 0);
            check("stall_c00", 32'(bus.idct_coeffs[0][0]), 32'(exp_blk[0][0]));
            step();
        end
        bus.idct_done = 1'b0;
        bus.result_ready = 1'b1;
        @(negedge clk);
        check("out_valid", 32'(bus.result_valid), 1);
        check("out_chan", 32'(bus.result_chan), 32'(w));
        check("out_ready", 32'(bus.req_ready), 0);
        check_block("hold_out");
        step();
        bus.result_ready = 1'b0;
    endtask

    initial begin
        int w;
        rst = 1'b1;
        pend = '0;
        last_g = NR - 1;
        bus.req_valid = '1;
        bus.idct_done = 1'b0;
        bus.result_ready = 1'b0;
        for (int i = 0; i < int'(NR); i++) rand_block(i);

        // Reset values, with requests present to prove req_ready stays low.
        @(negedge clk);
        check("rst_ready", 32'(bus.req_ready), 0);
        check("rst_start", 32'(bus.idct_start), 0);
        check("rst_valid", 32'(bus.result_valid), 0);
        check("rst_chan", 32'(bus.result_chan), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_err", 32'(bus.err_timeout), 0);
        check("rst_c00", 32'(bus.idct_coeffs[0][0]), 0);
        check("rst_c77", 32'(bus.idct_coeffs[7][7]), 0);
        step();
        bus.req_valid = '0;
        rst = 1'b0;
        step();

        // Single requester 1 with a known coefficient.
        pend = 3'b010;
        rand_block(1);
        bus.req_coeffs[1][0][0] = -16'sd1024;
        run_block(5, 3, 1'b1);
        check("c00_after_out", 32'(exp_blk[0][0]), 32'(-16'sd1024));

        // All requesters continuously valid, writer always ready.
        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < int'(NR); i++)
                if (!pend[i]) begin pend[i] = 1'b1; rand_block(i); end
            run_block(2, 0, 1'b0);
        end

        // Long writer stall with everyone waiting.
        pend = '1;
        run_block(3, 20, 1'b1);

        // Random traffic.
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 3) == 0) idle_cycle();
            refill();
            run_block($urandom_range(1, 10), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
        end

        // Reset in BUSY: outputs drop at once, round robin restarts at 0.
        pend = '1;
        grant_and_start(w);
        step();
        rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(bus.busy), 0);
        check("mid_rst_start", 32'(bus.idct_start), 0);
        check("mid_rst_valid", 32'(bus.result_valid), 0);
        check("mid_rst_ready", 32'(bus.req_ready), 0);
        check("mid_rst_chan", 32'(bus.result_chan), 0);
        step();
        rst = 1'b0;
        last_g = NR - 1;
        pend = '1;
        run_block(4, 1, 1'b0);

        // IDCT never answers.
        pend = 3'b001;
        grant_and_start(w);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
`ifdef IDCT_ARB_WATCHDOG_EN
            check("wd_busy", 32'(bus.busy), (i < int'(TO)) ? 1 : 0);
            check("wd_err", 32'(bus.err_timeout), (i >= int'(TO)) ? 1 : 0);
`else
            check("hang_busy", 32'(bus.busy), 1);
            check("hang_err", 32'(bus.err_timeout), 0);
`endif
            check("hang_valid", 32'(bus.result_valid), 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
